// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared constants and FSM state encoding for the data-memory
//               responder and its word RAM.
// Contents    : state_t / c_IDLE / c_WAIT / c_RESP  - responder FSM states
//               c_CNT_W                             - latency counter width
//               c_STRB_W                            - byte-strobe width
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int c_CNT_W  = 4;
    localparam int c_STRB_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t c_IDLE = 2'd0;
    localparam state_t c_WAIT = 2'd1;
    localparam state_t c_RESP = 2'd2;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Single-port 32-bit word RAM with byte-lane write strobes.
//               Read is combinational from the addressed word, so a caller
//               sampling rdata on a write edge sees the pre-write contents.
// Ports       : clk    in   clock
//               we     in   write enable
//               addr   in   word index [ADDR_WIDTH-1:0]
//               wdata  in   write data, little-endian byte lanes
//               wstrb  in   per-lane write enables
//               rdata  out  contents of the addressed word
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic [c_STRB_W-1:0]   wstrb,
    output logic [31:0]           rdata
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    // One byte-wide array per lane keeps each storage element written from
    // exactly one process.
    for (genvar i = 0; i < c_STRB_W; i++) begin : g_lane
        logic [7:0] r_mem [c_DEPTH];

        always_ff @(posedge clk) begin
            if (we && wstrb[i]) begin
                r_mem[addr] <= wdata[8*i +: 8];
            end
        end

        assign rdata[8*i +: 8] = r_mem[addr];
    end

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Load/store responder for the RV32I data port. Accepts one word
//               request at a time, commits stores on the accepting edge,
//               captures load data, and presents the response LATENCY cycles
//               later over a valid/ready handshake.
// Ports       : clk        in   clock
//               reset      in   asynchronous active-low reset
//               req_valid  in   request present
//               req_ready  out  request can be accepted (IDLE only)
//               req_we     in   1 = store, 0 = load
//               req_addr   in   byte address
//               req_wdata  in   store data
//               req_wstrb  in   store byte-lane enables
//               rsp_valid  out  response present
//               rsp_ready  in   requester takes response
//               rsp_rdata  out  load data (0 for stores / errors)
//               rsp_err    out  out-of-range or misaligned request
// Config      : DMEM_MISALIGN_ERR_EN - when defined, a request whose address
//               is not word aligned is rejected with rsp_err.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          LATENCY    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [31:0]         req_addr,
    input  logic [31:0]         req_wdata,
    input  logic [c_STRB_W-1:0] req_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [31:0]         rsp_rdata,
    output logic                rsp_err
);

    localparam logic [c_CNT_W-1:0] c_LAT_M1 = c_CNT_W'(LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    state_t              r_state;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_rdata;
    logic                r_rsp_err;
    logic [c_CNT_W-1:0]  r_cnt;

    logic [31:0]           w_offset;
    logic                  w_in_range;
    logic                  w_misalign;
    logic                  w_err;
    logic                  w_accept;
    logic                  w_ram_we;
    logic [ADDR_WIDTH-1:0] w_index;
    logic [31:0]           w_ram_rdata;
    logic                  w_unused_ok;

    // Offset wraps modulo 2^32; the explicit >= check rejects addresses below
    // the base that would otherwise wrap into a large offset anyway.
    assign w_offset   = req_addr - BASE_ADDR;
    assign w_in_range = (req_addr >= BASE_ADDR) &&
                        ((w_offset >> (ADDR_WIDTH + 2)) == 32'd0);
    assign w_index    = w_offset[ADDR_WIDTH+1:2];

`ifdef DMEM_MISALIGN_ERR_EN
    assign w_misalign = (req_addr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Byte offset within the word only matters for the misalignment check.
    assign w_unused_ok = &{1'b0, w_offset[1:0]};

    assign w_err    = !w_in_range || w_misalign;
    assign w_accept = req_valid && r_req_ready;
    assign w_ram_we = w_accept && req_we && !w_err;

    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_index),
        .wdata (req_wdata),
        .wstrb (req_wstrb),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= (!req_we && !w_err) ? w_ram_rdata : 32'd0;
                        r_cnt       <= c_LAT_M1;
                        if (LATENCY == 1) begin
                            r_state     <= c_RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state <= c_WAIT;
                        end
                    end
                end
                c_WAIT: begin
                    if (r_cnt == c_CNT_ONE) begin
                        r_state     <= c_RESP;
                        r_rsp_valid <= 1'b1;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= c_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= c_IDLE;
                    r_req_ready <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule : dmem_responder
`default_nettype wire
